// File: rtl/accessor_pkg.sv
// accessor_pkg: shared types and constants for the memory-access stage.
//   state_t  : stage FSM states
//   size_t   : memory access size
//   WSTRB_*  : byte-strobe patterns for the data-memory bus
package accessor_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned STRB_W = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    OUT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_t;

  localparam logic [STRB_W-1:0] WSTRB_NONE = 4'b0000;
  localparam logic [STRB_W-1:0] WSTRB_B0   = 4'b0001;
  localparam logic [STRB_W-1:0] WSTRB_B1   = 4'b0010;
  localparam logic [STRB_W-1:0] WSTRB_B2   = 4'b0100;
  localparam logic [STRB_W-1:0] WSTRB_B3   = 4'b1000;
  localparam logic [STRB_W-1:0] WSTRB_HLO  = 4'b0011;
  localparam logic [STRB_W-1:0] WSTRB_HHI  = 4'b1100;
  localparam logic [STRB_W-1:0] WSTRB_W    = 4'b1111;

  // Strobe for a single byte lane.
  function automatic logic [STRB_W-1:0] byte_strobe(input logic [1:0] lane);
    case (lane)
      2'd0:    byte_strobe = WSTRB_B0;
      2'd1:    byte_strobe = WSTRB_B1;
      2'd2:    byte_strobe = WSTRB_B2;
      default: byte_strobe = WSTRB_B3;
    endcase
  endfunction

endpackage

// File: rtl/accessor_load_extend.sv
// accessor_load_extend: lane select plus sign/zero extension of load data.
//   rdata     in  raw 32-bit word from the bus
//   addr_lo   in  low two bits of the byte address
//   size      in  access size (byte/half/word)
//   is_signed in  sign-extend when set, zero-extend otherwise
//   data      out extended load value
module accessor_load_extend
  import accessor_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  size_t           size,
  input  logic            is_signed,
  output logic [XLEN-1:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Select the addressed byte and halfword, then extend by size.
  always_comb begin
    lane_b = rdata[7:0];
    lane_h = rdata[15:0];
    data   = rdata;
    case (addr_lo)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SIZE_B:  data = {{24{is_signed & lane_b[7]}}, lane_b};
      SIZE_H:  data = {{16{is_signed & lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/accessor.sv
// accessor: memory-access pipeline stage between execute and writeback.
// Accepts one operation per executor handshake, issues loads/stores on a
// single-ported data bus, extends load data, packs store data/strobes and
// hands rd/rd_data to writeback under a valid/ready handshake.
// Optional build macro ACCESSOR_MISALIGN_TRAP_EN: misaligned half/word
// accesses skip the bus and raise accessor_trap; otherwise accessor_trap is 0.
// Ports:
//   clk, reset (sync, active-high)
//   executor_*      upstream operation and handshake
//   accessor_ready  stage can accept this cycle (combinational)
//   accessor_valid/accessor_rd/accessor_rd_data/accessor_trap  to writeback
//   writeback_ready downstream consumes result
//   mem_*           data-memory bus request/response
module accessor
  import accessor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              executor_valid,
  output logic              accessor_ready,
  output logic              accessor_valid,
  input  logic              writeback_ready,
  input  logic [REG_W-1:0]  executor_rd,
  input  logic [XLEN-1:0]   executor_rd_data,
  input  logic [XLEN-1:0]   executor_mem_addr,
  input  logic [XLEN-1:0]   executor_mem_data,
  input  logic              executor_is_lui,
  input  logic              executor_is_lb,
  input  logic              executor_is_lbu,
  input  logic              executor_is_lh,
  input  logic              executor_is_lhu,
  input  logic              executor_is_lw,
  input  logic              executor_is_sb,
  input  logic              executor_is_sh,
  input  logic              executor_is_sw,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic [REG_W-1:0]  accessor_rd,
  output logic [XLEN-1:0]   accessor_rd_data,
  output logic              accessor_trap
);

  state_t           state;
  logic [REG_W-1:0] ld_rd;
  size_t            ld_size;
  logic             ld_signed;
  logic             ld_store;
  logic [1:0]       ld_lo;
  logic [XLEN-1:0]  load_data;

  logic             accept;
  logic             op_load;
  logic             op_store;
  logic             op_misalign;
  size_t            op_size;
  logic [XLEN-1:0]  st_wdata;
  logic [STRB_W-1:0] st_wstrb;

  assign accessor_ready = (state == IDLE) || ((state == OUT) && writeback_ready);
  assign accept         = executor_valid && accessor_ready;

  // Decode the incoming operation and pre-pack store data and strobes.
  always_comb begin
    op_load  = executor_is_lb | executor_is_lbu | executor_is_lh |
               executor_is_lhu | executor_is_lw;
    op_store = executor_is_sb | executor_is_sh | executor_is_sw;
    op_size  = SIZE_W;
    st_wdata = executor_mem_data;
    st_wstrb = WSTRB_W;
    if (executor_is_lb || executor_is_lbu || executor_is_sb) begin
      op_size = SIZE_B;
    end else if (executor_is_lh || executor_is_lhu || executor_is_sh) begin
      op_size = SIZE_H;
    end
    if (executor_is_sb) begin
      st_wdata = {4{executor_mem_data[7:0]}};
      st_wstrb = byte_strobe(executor_mem_addr[1:0]);
    end else if (executor_is_sh) begin
      st_wdata = {2{executor_mem_data[15:0]}};
      st_wstrb = executor_mem_addr[1] ? WSTRB_HHI : WSTRB_HLO;
    end
  end

`ifdef ACCESSOR_MISALIGN_TRAP_EN
  logic trap_q;

  assign op_misalign = ((executor_is_lh | executor_is_lhu | executor_is_sh) &
                        executor_mem_addr[0]) |
                       ((executor_is_lw | executor_is_sw) &
                        (|executor_mem_addr[1:0]));
  assign accessor_trap = trap_q;
`else
  assign op_misalign   = 1'b0;
  assign accessor_trap = 1'b0;
`endif

  accessor_load_extend u_load_extend (
    .rdata     (mem_rdata),
    .addr_lo   (ld_lo),
    .size      (ld_size),
    .is_signed (ld_signed),
    .data      (load_data)
  );

  // Stage FSM with registered bus and writeback outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_valid        <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_wstrb        <= WSTRB_NONE;
      accessor_valid   <= 1'b0;
      accessor_rd      <= '0;
      accessor_rd_data <= '0;
      ld_rd            <= '0;
      ld_size          <= SIZE_W;
      ld_signed        <= 1'b0;
      ld_store         <= 1'b0;
      ld_lo            <= 2'd0;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
      trap_q           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, OUT: begin
          // Result consumed; a same-cycle accept below overrides these.
          if ((state == OUT) && writeback_ready) begin
            state          <= IDLE;
            accessor_valid <= 1'b0;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
            trap_q         <= 1'b0;
`endif
          end
          if (accept) begin
            ld_rd     <= executor_rd;
            ld_size   <= op_size;
            ld_signed <= executor_is_lb | executor_is_lh;
            ld_store  <= op_store;
            ld_lo     <= executor_mem_addr[1:0];
            if (op_misalign) begin
              state            <= OUT;
              accessor_valid   <= 1'b1;
              accessor_rd      <= '0;
              accessor_rd_data <= '0;
`ifdef ACCESSOR_MISALIGN_TRAP_EN
              trap_q           <= 1'b1;
`endif
            end else if (op_load || op_store) begin
              state          <= BUS;
              accessor_valid <= 1'b0;
              mem_valid      <= 1'b1;
              mem_addr       <= {executor_mem_addr[XLEN-1:2], 2'b00};
              mem_wdata      <= st_wdata;
              mem_wstrb      <= op_store ? st_wstrb : WSTRB_NONE;
            end else begin
              state            <= OUT;
              accessor_valid   <= 1'b1;
              accessor_rd      <= executor_rd;
              accessor_rd_data <= executor_is_lui ? executor_mem_addr : executor_rd_data;
            end
          end
        end
        BUS: begin
          // Request held stable until the bus completes it.
          if (mem_ready) begin
            state            <= OUT;
            mem_valid        <= 1'b0;
            mem_wstrb        <= WSTRB_NONE;
            accessor_valid   <= 1'b1;
            accessor_rd      <= ld_store ? '0 : ld_rd;
            accessor_rd_data <= ld_store ? '0 : load_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accessor.sv
// tb_accessor: directed self-checking bench for the accessor stage.
module tb_accessor;

  logic        clk = 1'b0;
  logic        reset;
  logic        executor_valid;
  logic        accessor_ready;
  logic        accessor_valid;
  logic        writeback_ready;
  logic [4:0]  executor_rd;
  logic [31:0] executor_rd_data;
  logic [31:0] executor_mem_addr;
  logic [31:0] executor_mem_data;
  logic        executor_is_lui, executor_is_lb, executor_is_lbu, executor_is_lh;
  logic        executor_is_lhu, executor_is_lw, executor_is_sb, executor_is_sh;
  logic        executor_is_sw;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic [4:0]  accessor_rd;
  logic [31:0] accessor_rd_data;
  logic        accessor_trap;

  localparam logic [8:0] F_NONE = 9'b0_0000_0000;
  localparam logic [8:0] F_LUI  = 9'b1_0000_0000;
  localparam logic [8:0] F_LB   = 9'b0_1000_0000;
  localparam logic [8:0] F_LBU  = 9'b0_0100_0000;
  localparam logic [8:0] F_LH   = 9'b0_0010_0000;
  localparam logic [8:0] F_LHU  = 9'b0_0001_0000;
  localparam logic [8:0] F_LW   = 9'b0_0000_1000;
  localparam logic [8:0] F_SB   = 9'b0_0000_0100;
  localparam logic [8:0] F_SH   = 9'b0_0000_0010;
  localparam logic [8:0] F_SW   = 9'b0_0000_0001;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  accessor dut (
    .clk               (clk),
    .reset             (reset),
    .executor_valid    (executor_valid),
    .accessor_ready    (accessor_ready),
    .accessor_valid    (accessor_valid),
    .writeback_ready   (writeback_ready),
    .executor_rd       (executor_rd),
    .executor_rd_data  (executor_rd_data),
    .executor_mem_addr (executor_mem_addr),
    .executor_mem_data (executor_mem_data),
    .executor_is_lui   (executor_is_lui),
    .executor_is_lb    (executor_is_lb),
    .executor_is_lbu   (executor_is_lbu),
    .executor_is_lh    (executor_is_lh),
    .executor_is_lhu   (executor_is_lhu),
    .executor_is_lw    (executor_is_lw),
    .executor_is_sb    (executor_is_sb),
    .executor_is_sh    (executor_is_sh),
    .executor_is_sw    (executor_is_sw),
    .mem_valid         (mem_valid),
    .mem_ready         (mem_ready),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_rdata         (mem_rdata),
    .accessor_rd       (accessor_rd),
    .accessor_rd_data  (accessor_rd_data),
    .accessor_trap     (accessor_trap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_flags(input logic [8:0] f);
    {executor_is_lui, executor_is_lb, executor_is_lbu, executor_is_lh, executor_is_lhu,
     executor_is_lw, executor_is_sb, executor_is_sh, executor_is_sw} = f;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE with writeback_ready high, serve the bus after
  // 'waits' stall cycles, capture the result and let writeback consume it.
  task automatic run_op(input logic [8:0] flags, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] addr,
                        input logic [31:0] sdata, input int waits,
                        input logic [31:0] rdata,
                        output logic [31:0] o_addr, output logic [31:0] o_wdata,
                        output logic [3:0] o_wstrb, output int hold,
                        output logic o_stable, output logic o_valid,
                        output logic o_trap, output logic [4:0] o_rd,
                        output logic [31:0] o_data);
    set_flags(flags);
    executor_valid    = 1'b1;
    executor_rd       = rd;
    executor_rd_data  = alu;
    executor_mem_addr = addr;
    executor_mem_data = sdata;
    step();
    executor_valid = 1'b0;
    set_flags(F_NONE);
    o_addr   = mem_addr;
    o_wdata  = mem_wdata;
    o_wstrb  = mem_wstrb;
    hold     = 0;
    o_stable = 1'b1;
    while (mem_valid && hold < 64) begin
      hold++;
      if (mem_addr !== o_addr || mem_wdata !== o_wdata || mem_wstrb !== o_wstrb ||
          accessor_ready !== 1'b0)
        o_stable = 1'b0;
      mem_ready = (hold > waits);
      mem_rdata = mem_ready ? rdata : 32'hDEAD_BEEF;
      step();
    end
    mem_ready = 1'b0;
    o_valid   = accessor_valid;
    o_trap    = accessor_trap;
    o_rd      = accessor_rd;
    o_data    = accessor_rd_data;
    step();
    check("consumed_valid", 32'(accessor_valid), 32'd0);
  endtask

  logic [31:0] a, wd, d;
  logic [3:0]  ws;
  logic [4:0]  r;
  logic        st, v, tr;
  int          h;

  initial begin
    reset = 1'b1;
    executor_valid = 1'b0;
    writeback_ready = 1'b1;
    executor_rd = '0;
    executor_rd_data = '0;
    executor_mem_addr = '0;
    executor_mem_data = '0;
    set_flags(F_NONE);
    mem_ready = 1'b0;
    mem_rdata = '0;
    step();
    step();
    reset = 1'b0;
    check("rst_acc_valid", 32'(accessor_valid), 32'd0);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_ready", 32'(accessor_ready), 32'd1);
    check("rst_rd_data", accessor_rd_data, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_trap", 32'(accessor_trap), 32'd0);

    // ALU result: one-cycle latency, no bus activity
    run_op(F_NONE, 5'd5, 32'h0000_0007, 32'h0000_0000, 32'h0, 0, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("add_hold", 32'(h), 32'd0);
    check("add_valid", 32'(v), 32'd1);
    check("add_rd", 32'(r), 32'd5);
    check("add_data", d, 32'h0000_0007);

    // LUI takes its value from the address operand
    run_op(F_LUI, 5'd3, 32'h1111_1111, 32'h1234_5000, 32'h0, 0, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("lui_data", d, 32'h1234_5000);
    check("lui_rd", 32'(r), 32'd3);

    // LB with three wait states
    run_op(F_LB, 5'd7, 32'h0, 32'h0000_0103, 32'h0, 3, 32'h80AA_BBCC,
           a, wd, ws, h, st, v, tr, r, d);
    check("lb_addr", a, 32'h0000_0100);
    check("lb_wstrb", 32'(ws), 32'd0);
    check("lb_hold", 32'(h), 32'd4);
    check("lb_stable", 32'(st), 32'd1);
    check("lb_valid", 32'(v), 32'd1);
    check("lb_rd", 32'(r), 32'd7);
    check("lb_data", d, 32'hFFFF_FF80);

    run_op(F_LHU, 5'd8, 32'h0, 32'h0000_0102, 32'h0, 0, 32'h8001_1234,
           a, wd, ws, h, st, v, tr, r, d);
    check("lhu_hold", 32'(h), 32'd1);
    check("lhu_data", d, 32'h0000_8001);

    run_op(F_LH, 5'd8, 32'h0, 32'h0000_0102, 32'h0, 1, 32'h8001_1234,
           a, wd, ws, h, st, v, tr, r, d);
    check("lh_hold", 32'(h), 32'd2);
    check("lh_data", d, 32'hFFFF_8001);

    run_op(F_LBU, 5'd9, 32'h0, 32'h0000_0101, 32'h0, 0, 32'h1122_8033,
           a, wd, ws, h, st, v, tr, r, d);
    check("lbu_data", d, 32'h0000_0080);

    run_op(F_LW, 5'd10, 32'h0, 32'h0000_0044, 32'h0, 0, 32'h89AB_CDEF,
           a, wd, ws, h, st, v, tr, r, d);
    check("lw_addr", a, 32'h0000_0044);
    check("lw_data", d, 32'h89AB_CDEF);

    // Stores: lane replication, strobes, no writeback destination
    run_op(F_SB, 5'd12, 32'h0, 32'h0000_0021, 32'h1234_56AB, 0, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("sb_addr", a, 32'h0000_0020);
    check("sb_wdata", wd, 32'hABAB_ABAB);
    check("sb_wstrb", 32'(ws), 32'h2);
    check("sb_rd", 32'(r), 32'd0);
    check("sb_data", d, 32'd0);
    check("sb_valid", 32'(v), 32'd1);

    run_op(F_SH, 5'd13, 32'h0, 32'h0000_0022, 32'h0000_BEEF, 0, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("sh_wdata", wd, 32'hBEEF_BEEF);
    check("sh_wstrb", 32'(ws), 32'hC);
    check("sh_rd", 32'(r), 32'd0);

    run_op(F_SW, 5'd14, 32'h0, 32'h0000_0040, 32'hCAFE_F00D, 2, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("sw_wdata", wd, 32'hCAFE_F00D);
    check("sw_wstrb", 32'(ws), 32'hF);
    check("sw_hold", 32'(h), 32'd3);
    check("sw_stable", 32'(st), 32'd1);

    // Writeback back-pressure, then back-to-back accepts on release
    writeback_ready   = 1'b0;
    executor_valid    = 1'b1;
    executor_rd       = 5'd9;
    executor_rd_data  = 32'h0000_A5A5;
    executor_mem_addr = 32'h0;
    step();
    executor_valid = 1'b0;
    check("stall_valid", 32'(accessor_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_ready", 32'(accessor_ready), 32'd0);
      check("stall_rd", 32'(accessor_rd), 32'd9);
      check("stall_data", accessor_rd_data, 32'h0000_A5A5);
    end
    writeback_ready  = 1'b1;
    executor_valid   = 1'b1;
    executor_rd      = 5'd10;
    executor_rd_data = 32'h0000_0055;
    #1;
    check("b2b_ready", 32'(accessor_ready), 32'd1);
    step();
    check("b2b1_valid", 32'(accessor_valid), 32'd1);
    check("b2b1_rd", 32'(accessor_rd), 32'd10);
    check("b2b1_data", accessor_rd_data, 32'h0000_0055);
    executor_rd      = 5'd11;
    executor_rd_data = 32'h0000_0066;
    step();
    executor_valid = 1'b0;
    check("b2b2_rd", 32'(accessor_rd), 32'd11);
    check("b2b2_data", accessor_rd_data, 32'h0000_0066);
    step();
    check("b2b_drain", 32'(accessor_valid), 32'd0);

    // Reset in the middle of a bus transfer
    set_flags(F_LW);
    executor_valid    = 1'b1;
    executor_rd       = 5'd4;
    executor_mem_addr = 32'h0000_0080;
    step();
    executor_valid = 1'b0;
    set_flags(F_NONE);
    check("mid_bus_mem_valid", 32'(mem_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstbus_mem_valid", 32'(mem_valid), 32'd0);
    check("rstbus_acc_valid", 32'(accessor_valid), 32'd0);
    check("rstbus_ready", 32'(accessor_ready), 32'd1);

    // Misaligned word store
`ifdef ACCESSOR_MISALIGN_TRAP_EN
    run_op(F_SW, 5'd6, 32'h0, 32'h0000_0002, 32'h1234_5678, 0, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("mis_hold", 32'(h), 32'd0);
    check("mis_trap", 32'(tr), 32'd1);
    check("mis_valid", 32'(v), 32'd1);
    check("mis_rd", 32'(r), 32'd0);
    check("mis_trap_clear", 32'(accessor_trap), 32'd0);
`else
    run_op(F_SW, 5'd6, 32'h0, 32'h0000_0002, 32'h1234_5678, 0, 32'h0,
           a, wd, ws, h, st, v, tr, r, d);
    check("mis_hold", 32'(h), 32'd1);
    check("mis_addr", a, 32'h0000_0000);
    check("mis_wstrb", 32'(ws), 32'hF);
    check("mis_trap", 32'(tr), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
